uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//  Sits downstream of the UART core. Pops received bytes from the UART RX FIFO and hunts for
//  framed packets: SYNC, LEN, LEN payload bytes, CSUM. Stores the payload in an internal buffer
//  and answers each frame with ACK or NAK through the UART TX FIFO.
//  Presents a complete, checksum-valid frame to the consumer until the consumer releases it.
// PARAMETERS
//  DBIT        8      data byte width (matches UART DBIT)
//  MAX_LEN     16     max payload bytes per frame (1..255)
//  SYNC_BYTE   8'hA5  frame start marker
//  ACK_BYTE    8'h06  response sent for a good frame
//  NAK_BYTE    8'h15  response sent for a bad length or bad checksum
//  TIMEOUT_CYC 100000 idle clk cycles allowed between bytes inside a frame
// PORTS
//  clk          in   1                      system clock
//  reset        in   1                      synchronous, active-high reset
//  rx_empty     in   1                      UART RX FIFO empty
//  r_data       in   DBIT                   UART RX FIFO head; valid when !rx_empty, first-word-fall-through
//  rd_uart      out  1                      pop UART RX FIFO; the byte is taken from r_data in the same cycle
//  tx_full      in   1                      UART TX FIFO full
//  wr_uart      out  1                      push w_data into UART TX FIFO
//  w_data       out  DBIT                   response byte
//  frame_valid  out  1                      buffered frame ready (level)
//  frame_len    out  $clog2(MAX_LEN+1)      payload length of the buffered frame
//  pl_addr      in   $clog2(MAX_LEN)        payload buffer read index
//  pl_data      out  DBIT                   buf[pl_addr]; combinational read
//  frame_ack    in   1                      consumer release; sampled only while frame_valid
//  timeout      out  1                      1-cycle pulse when a partial frame is abandoned
// BEHAVIOUR
//  Reset: state=HUNT. rd_uart, wr_uart, frame_valid and timeout are 0. frame_len=0, w_data=0,
//   idle counter=0. Buffer contents are don't-care.
//  rd_uart = !rx_empty && state in {HUNT,LEN,PAYLOAD,CSUM}. Combinational; at most 1 pop per cycle.
//  Checksum: 8-bit wrap sum of LEN, all payload bytes and CSUM must equal 8'h00.
//  FSM (each "pop" means a cycle with rd_uart=1):
//   HUNT    pop: byte==SYNC_BYTE -> LEN; else discard and stay.
//   LEN     pop: byte==0 or byte>MAX_LEN -> resp=NAK, go RESP.
//           Otherwise len=byte, sum=byte, idx=0 -> PAYLOAD.
//   PAYLOAD pop: buf[idx]=byte, sum+=byte, idx++; after the LEN-th byte -> CSUM.
//   CSUM    pop: (sum+byte)==0 -> resp=ACK, good=1; else resp=NAK, good=0. Go RESP.
//   RESP    w_data=resp. wr_uart=!tx_full. On the push: good ? HOLD : HUNT.
//           Stalls indefinitely while tx_full.
//   HOLD    frame_valid=1, frame_len=len. No pops, so RX bytes back up in the UART FIFO.
//           frame_ack=1 -> frame_valid=0 next cycle, state HUNT.
//  Latency: wr_uart can assert at the earliest 1 cycle after the CSUM pop.
//   frame_valid rises the cycle after the ACK push.
//  Timeout: in LEN/PAYLOAD/CSUM the idle counter increments each cycle without a pop and clears
//   on every pop. When it reaches TIMEOUT_CYC: timeout pulses 1 cycle, state -> HUNT, no response
//   is sent. The counter is held at 0 in HUNT, RESP and HOLD.
//  A SYNC_BYTE value inside LEN/PAYLOAD/CSUM is ordinary data; there is no resync mid-frame.
//  frame_ack outside HOLD is ignored. The buffer is overwritten only by the next frame's PAYLOAD.
//  Reset mid-frame or mid-RESP: partial frame discarded, no response sent, return to HUNT.
//  pl_addr >= frame_len: pl_data is don't-care.
// TESTING
//  1. RX bytes A5 03 11 22 33 97 -> one wr_uart with w_data=06; frame_valid=1, frame_len=3,
//     pl_data[0..2]=11,22,33.
//  2. Same frame with CSUM=98 -> w_data=15 (NAK); frame_valid stays 0; the next good frame is
//     accepted.
//  3. Bytes 00 FF 3C, then A5 01 7E 81 -> leading garbage popped and dropped; ACK 06; frame_len=1,
//     pl_data[0]=7E.
//  4. A5 00, and separately A5 11 (17 > MAX_LEN 16) -> NAK 15 each; no PAYLOAD state entered.
//  5. A5 02 11, then RX idle for TIMEOUT_CYC cycles -> timeout pulse, no wr_uart.
//     A following good frame -> ACK.
//  6. tx_full=1 held for 50 cycles in RESP -> wr_uart stays 0, then pushes once when tx_full
//     drops. In HOLD with RX bytes pending -> rd_uart=0 until frame_ack.
//     Assert reset mid-PAYLOAD -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder
//
// Purpose:
//   Sits downstream of a UART core. Pops received bytes from the UART RX FIFO
//   and hunts for framed packets of the form
//      SYNC, LEN, LEN payload bytes, CSUM
//   The payload is stored in an internal buffer. Every frame that reaches a
//   length or checksum verdict is answered with ACK or NAK through the UART
//   TX FIFO. A complete, checksum-valid frame is presented to the consumer
//   (frame_valid/frame_len/pl_data) until the consumer releases it with
//   frame_ack. A partial frame that goes idle for TIMEOUT_CYC cycles is
//   abandoned silently with a one-cycle timeout pulse.
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   rx_empty     in   1      UART RX FIFO empty
//   r_data       in   DBIT   UART RX FIFO head (first-word-fall-through)
//   rd_uart      out  1      pop UART RX FIFO; byte taken from r_data this cycle
//   tx_full      in   1      UART TX FIFO full
//   wr_uart      out  1      push w_data into UART TX FIFO
//   w_data       out  DBIT   response byte (ACK_BYTE / NAK_BYTE)
//   frame_valid  out  1      buffered frame ready (level)
//   frame_len    out  LEN_W  payload length of the buffered frame
//   pl_addr      in   ADDR_W payload buffer read index
//   pl_data      out  DBIT   payload byte at pl_addr (combinational read)
//   frame_ack    in   1      consumer release, honoured only while frame_valid
//   timeout      out  1      1-cycle pulse when a partial frame is abandoned
// ---------------------------------------------------------------------------
module uart_frame_decoder #(
   parameter int              DBIT        = 8,
   parameter int              MAX_LEN     = 16,
   parameter logic [DBIT-1:0] SYNC_BYTE   = 8'hA5,
   parameter logic [DBIT-1:0] ACK_BYTE    = 8'h06,
   parameter logic [DBIT-1:0] NAK_BYTE    = 8'h15,
   parameter int              TIMEOUT_CYC = 100000,
   localparam int             LEN_W       = $clog2(MAX_LEN + 1),
   localparam int             ADDR_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [DBIT-1:0]   r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [DBIT-1:0]   w_data,
   output logic              frame_valid,
   output logic [LEN_W-1:0]  frame_len,
   input  logic [ADDR_W-1:0] pl_addr,
   output logic [DBIT-1:0]   pl_data,
   input  logic              frame_ack,
   output logic              timeout
);

   localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 1);
   // The counter value seen on the last idle cycle before the frame is dropped:
   // when it would step from TIMEOUT_CYC-1 to TIMEOUT_CYC, the timeout fires.
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
   // MAX_LEN widened by one bit so that the length byte can be compared
   // without truncating either side.
   localparam logic [DBIT:0]    MAX_LEN_EXT = (DBIT + 1)'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_RESP,
      ST_HOLD
   } state_t;

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   len_reg, len_next;
   logic [LEN_W-1:0]   idx_reg, idx_next;
   logic [DBIT-1:0]    sum_reg, sum_next;
   logic [DBIT-1:0]    resp_reg, resp_next;
   logic               good_reg, good_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               timeout_reg, timeout_next;

   // Payload buffer: written one byte per PAYLOAD pop, read asynchronously by
   // the consumer. It is never cleared; it simply holds the last frame's bytes.
   logic [DBIT-1:0]    buf_mem [MAX_LEN];
   logic               buf_we;
   logic [ADDR_W-1:0]  buf_waddr;

   logic               rx_active;
   logic               in_frame;
   logic               pop;
   logic               len_bad;
   logic [DBIT-1:0]    csum_total;

   // States that consume RX bytes, and the subset that is inside a frame and
   // therefore subject to the idle timeout.
   assign rx_active  = (state_reg == ST_HUNT)    || (state_reg == ST_LEN) ||
                       (state_reg == ST_PAYLOAD) || (state_reg == ST_CSUM);
   assign in_frame   = (state_reg == ST_LEN)     || (state_reg == ST_PAYLOAD) ||
                       (state_reg == ST_CSUM);
   assign pop        = rx_active && !rx_empty;

   // Zero-length frames and frames longer than the buffer are both rejected.
   assign len_bad    = (r_data == '0) || ({1'b0, r_data} > MAX_LEN_EXT);
   // Wrap-around sum of LEN, payload and CSUM; a good frame totals zero.
   assign csum_total = sum_reg + r_data;

   assign buf_waddr  = ADDR_W'(idx_reg);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_HUNT;
         len_reg     <= '0;
         idx_reg     <= '0;
         sum_reg     <= '0;
         resp_reg    <= '0;
         good_reg    <= 1'b0;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         len_reg     <= len_next;
         idx_reg     <= idx_next;
         sum_reg     <= sum_next;
         resp_reg    <= resp_next;
         good_reg    <= good_next;
         cnt_reg     <= cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   // Buffer contents are don't-care after reset, so the write port carries
   // no reset term.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_mem[buf_waddr] <= r_data;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      idx_next     = idx_reg;
      sum_next     = sum_reg;
      resp_next    = resp_reg;
      good_next    = good_reg;
      cnt_next     = '0;
      timeout_next = 1'b0;
      buf_we       = 1'b0;

      case (state_reg)
         ST_HUNT: begin
            // Anything that is not a SYNC byte is popped and dropped.
            if (pop && (r_data == SYNC_BYTE)) begin
               state_next = ST_LEN;
            end
         end

         ST_LEN: begin
            if (pop) begin
               if (len_bad) begin
                  resp_next  = NAK_BYTE;
                  good_next  = 1'b0;
                  state_next = ST_RESP;
               end else begin
                  len_next   = LEN_W'(r_data);
                  sum_next   = r_data;
                  idx_next   = '0;
                  state_next = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            if (pop) begin
               buf_we   = 1'b1;
               sum_next = csum_total;
               idx_next = idx_reg + LEN_W'(1);
               if (idx_reg == (len_reg - LEN_W'(1))) begin
                  state_next = ST_CSUM;
               end
            end
         end

         ST_CSUM: begin
            if (pop) begin
               if (csum_total == '0) begin
                  resp_next = ACK_BYTE;
                  good_next = 1'b1;
               end else begin
                  resp_next = NAK_BYTE;
                  good_next = 1'b0;
               end
               state_next = ST_RESP;
            end
         end

         ST_RESP: begin
            // The response waits here for as long as the TX FIFO stays full.
            if (!tx_full) begin
               state_next = good_reg ? ST_HOLD : ST_HUNT;
            end
         end

         ST_HOLD: begin
            // No pops here: incoming bytes queue up in the UART RX FIFO
            // until the consumer has finished with the buffer.
            if (frame_ack) begin
               state_next = ST_HUNT;
            end
         end

         default: begin
            state_next = ST_HUNT;
         end
      endcase

      // Idle timeout inside a frame. A pop always restarts the count, so the
      // timeout branch only runs on cycles where the case above left the
      // state untouched.
      if (in_frame) begin
         if (pop) begin
            cnt_next = '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_next     = '0;
            timeout_next = 1'b1;
            state_next   = ST_HUNT;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rd_uart     = pop;
   assign wr_uart     = (state_reg == ST_RESP) && !tx_full;
   assign w_data      = (state_reg == ST_RESP) ? resp_reg : '0;
   assign frame_valid = (state_reg == ST_HOLD);
   assign frame_len   = frame_valid ? len_reg : '0;
   assign pl_data     = buf_mem[pl_addr];
   assign timeout     = timeout_reg;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_decoder
//
// Directed bench for uart_frame_decoder. The UART RX FIFO is modelled as a
// byte array with head/tail indices; TX pushes are logged. Expected values
// are hand-computed frame bytes and responses.
// ---------------------------------------------------------------------------
module tb_uart_frame_decoder;

   localparam int DBIT    = 8;
   localparam int MAX_LEN = 16;
   localparam int TOUT    = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic       tx_full = 1'b0;
   logic       wr_uart;
   logic [7:0] w_data;
   logic       frame_valid;
   logic [4:0] frame_len;
   logic [3:0] pl_addr = '0;
   logic [7:0] pl_data;
   logic       frame_ack = 1'b0;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   // RX FIFO model (first-word-fall-through)
   logic [7:0] rx_mem [0:255];
   int         rx_head = 0;
   int         rx_tail = 0;

   // TX log and timeout pulse counter
   logic [7:0] tx_log [0:63];
   int         tx_cnt = 0;
   int         to_cnt = 0;

   assign rx_empty = (rx_head == rx_tail);
   assign r_data   = rx_mem[rx_head[7:0]];

   uart_frame_decoder #(
      .DBIT        (DBIT),
      .MAX_LEN     (MAX_LEN),
      .SYNC_BYTE   (8'hA5),
      .ACK_BYTE    (8'h06),
      .NAK_BYTE    (8'h15),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_empty    (rx_empty),
      .r_data      (r_data),
      .rd_uart     (rd_uart),
      .tx_full     (tx_full),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .pl_addr     (pl_addr),
      .pl_data     (pl_data),
      .frame_ack   (frame_ack),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_uart) begin
         rx_head <= rx_head + 1;
      end
      if (wr_uart) begin
         tx_log[tx_cnt[5:0]] <= w_data;
         tx_cnt              <= tx_cnt + 1;
         $display("tx push #%0d data=%02h", tx_cnt, w_data);
      end
      if (timeout) begin
         to_cnt <= to_cnt + 1;
         $display("timeout pulse #%0d", to_cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      rx_mem[rx_tail[7:0]] = b;
      rx_tail++;
   endtask

   // Pushes n bytes, most significant byte first.
   task automatic send(input int n, input logic [63:0] bytes);
      for (int i = 0; i < n; i++) begin
         push(bytes[8*(n-1-i) +: 8]);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tx(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (tx_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, tx_cnt, n);
   endtask

   task automatic read_pl(input string tag, input logic [3:0] addr, input logic [7:0] exp);
      pl_addr = addr;
      #1;
      check(tag, pl_data, exp);
   endtask

   task automatic release_frame(input string tag);
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check(tag, frame_valid, 1'b0);
   endtask

   initial begin
      int wr_seen;
      int k;

      // ---------------- reset state ----------------
      reset = 1'b1;
      cycles(3);
      check("rst_rd_uart", rd_uart, 1'b0);
      check("rst_wr_uart", wr_uart, 1'b0);
      check("rst_frame_valid", frame_valid, 1'b0);
      check("rst_frame_len", frame_len, 5'd0);
      check("rst_w_data", w_data, 8'h00);
      check("rst_timeout", timeout, 1'b0);
      reset = 1'b0;
      cycles(2);

      // ---------------- 1: good 3-byte frame ----------------
      send(6, 48'hA5_03_11_22_33_97);
      wait_tx("t1_tx_count", 1, 40);
      check("t1_resp", tx_log[0], 8'h06);
      check("t1_frame_valid", frame_valid, 1'b1);
      check("t1_frame_len", frame_len, 5'd3);
      read_pl("t1_pl0", 4'd0, 8'h11);
      read_pl("t1_pl1", 4'd1, 8'h22);
      read_pl("t1_pl2", 4'd2, 8'h33);
      cycles(3);
      check("t1_single_push", tx_cnt, 1);
      release_frame("t1_release");

      // ---------------- 2: bad checksum, then good frame ----------------
      send(6, 48'hA5_03_11_22_33_98);
      wait_tx("t2_tx_count", 2, 40);
      check("t2_nak", tx_log[1], 8'h15);
      check("t2_no_frame", frame_valid, 1'b0);
      cycles(3);
      check("t2_no_frame_later", frame_valid, 1'b0);
      send(5, 40'hA5_02_40_50_6E);
      wait_tx("t2b_tx_count", 3, 40);
      check("t2b_ack", tx_log[2], 8'h06);
      check("t2b_frame_valid", frame_valid, 1'b1);
      check("t2b_frame_len", frame_len, 5'd2);
      read_pl("t2b_pl0", 4'd0, 8'h40);
      read_pl("t2b_pl1", 4'd1, 8'h50);
      release_frame("t2b_release");

      // ---------------- 3: leading garbage ----------------
      send(7, 56'h00_FF_3C_A5_01_7E_81);
      wait_tx("t3_tx_count", 4, 40);
      check("t3_ack", tx_log[3], 8'h06);
      check("t3_frame_len", frame_len, 5'd1);
      read_pl("t3_pl0", 4'd0, 8'h7E);
      check("t3_rx_drained", rx_empty, 1'b1);
      release_frame("t3_release");

      // ---------------- 4: zero and oversize length ----------------
      // A following good frame proves neither bad LEN entered PAYLOAD.
      send(8, 64'hA5_00_A5_11_A5_01_7E_81);
      wait_tx("t4_tx_count", 7, 60);
      check("t4_nak_len0", tx_log[4], 8'h15);
      check("t4_nak_len17", tx_log[5], 8'h15);
      check("t4_ack_after", tx_log[6], 8'h06);
      check("t4_frame_len", frame_len, 5'd1);
      release_frame("t4_release");

      // ---------------- 5: idle timeout ----------------
      send(3, 24'hA5_02_11);
      cycles(150);
      check("t5_no_early_timeout", to_cnt, 0);
      k = 0;
      while (to_cnt == 0 && k < 150) begin
         @(negedge clk);
         k++;
      end
      check("t5_timeout_seen", to_cnt, 1);
      cycles(5);
      check("t5_timeout_once", to_cnt, 1);
      check("t5_no_response", tx_cnt, 7);
      send(4, 32'hA5_01_7E_81);
      wait_tx("t5b_tx_count", 8, 40);
      check("t5b_ack", tx_log[7], 8'h06);
      release_frame("t5b_release");

      // ---------------- 6: TX back-pressure and HOLD ----------------
      tx_full = 1'b1;
      send(4, 32'hA5_01_7E_81);
      cycles(6);
      wr_seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_uart) wr_seen++;
      end
      check("t6_stall_no_wr", wr_seen, 0);
      check("t6_stall_tx_count", tx_cnt, 8);
      tx_full = 1'b0;
      wait_tx("t6_tx_count", 9, 10);
      check("t6_ack", tx_log[8], 8'h06);
      check("t6_frame_valid", frame_valid, 1'b1);
      send(2, 16'h55_66);
      cycles(5);
      check("t6_hold_no_pop", rd_uart, 1'b0);
      check("t6_hold_pending", rx_tail - rx_head, 2);
      release_frame("t6_release");
      cycles(4);
      check("t6_pending_drained", rx_empty, 1'b1);
      check("t6_garbage_no_resp", tx_cnt, 9);

      // Reset while in RESP: response must be dropped.
      tx_full = 1'b1;
      send(4, 32'hA5_01_7E_81);
      cycles(6);
      check("t6_resp_w_data", w_data, 8'h06);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_resp_w_data", w_data, 8'h00);
      check("t6_rst_resp_wr", wr_uart, 1'b0);
      reset = 1'b0;
      tx_full = 1'b0;
      cycles(5);
      check("t6_rst_resp_no_tx", tx_cnt, 9);

      // Reset mid-PAYLOAD: partial frame discarded.
      send(4, 32'hA5_04_01_02);
      cycles(6);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_rd_uart", rd_uart, 1'b0);
      check("t6_rst_wr_uart", wr_uart, 1'b0);
      check("t6_rst_frame_valid", frame_valid, 1'b0);
      check("t6_rst_frame_len", frame_len, 5'd0);
      check("t6_rst_timeout", timeout, 1'b0);
      reset = 1'b0;
      cycles(2);
      send(4, 32'hA5_01_7E_81);
      wait_tx("t6_post_rst_tx_count", 10, 40);
      check("t6_post_rst_ack", tx_log[9], 8'h06);
      check("t6_post_rst_len", frame_len, 5'd1);
      read_pl("t6_post_rst_pl0", 4'd0, 8'h7E);
      release_frame("t6_post_rst_release");
      check("t6_final_timeouts", to_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
